// File: rtl/multi_7_seg_scan.sv
// Time-multiplexed driver for NUM_DIGITS 7-segment digits with shadow load, leading-zero blanking and blink.
// Latency: one cycle from load/state change to outputs; no backpressure (free-running scan).
module multi_7_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    load_i,
    input  logic                    lzb_en_i,
    input  logic                    blink_en_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FCNT_W-1:0]     FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]            SEG_POL   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic                    ph_q, ph_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic       slot_end;
    logic       frame_end;
    logic       zero_run;
    logic [3:0] sel_nib;
    logic       sel_blank;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        fcnt_d = fcnt_q;
        ph_d   = ph_q;
        if (!blink_en_i) begin
            fcnt_d = '0;
            ph_d   = 1'b1;
        end else if (frame_end) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d = '0;
                ph_d   = ~ph_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        shadow_d = load_i ? digits_i : shadow_q;
    end

    // Outputs are built from the post-edge state so a load shows up one cycle later.
    always_comb begin
        zero_run  = 1'b1;
        sel_nib   = '0;
        sel_blank = 1'b0;
        an_d      = '0;
        seg_d     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (shadow_d[4*k +: 4] == 4'd0);
            if (idx_d == IDX_W'(k)) begin
                sel_nib   = shadow_d[4*k +: 4];
                sel_blank = zero_run && (k != 0);
            end
        end
        if ((cnt_d != '0) && ph_d) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_d[k] = (idx_d == IDX_W'(k));
            end
            seg_d = (lzb_en_i && sel_blank) ? 7'h00 : decode(sel_nib);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            fcnt_q   <= '0;
            ph_q     <= 1'b1;
            shadow_q <= '0;
            seg_q    <= SEG_POL;
            an_q     <= AN_POL;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fcnt_q   <= fcnt_d;
            ph_q     <= ph_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d ^ SEG_POL;
            an_q     <= an_d ^ AN_POL;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule
